arbitro_compuerta: RTL and testbench

ARBITRO_COMPUERTA -- requirements
Module: arbitro_compuerta

---
 rtl/arbitro_compuerta.sv | 201 ++++++++++++++++++++
 tb/tb_arbitro_compuerta.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_compuerta.sv
// -----------------------------------------------------------------------------
// arbitro_compuerta
//
// Four-requester arbiter that gates access to a small combinational function
// unit. A granted requester's operand nibble {a,b,c,d} is latched, the unit
// computes
//   x = ~((a & b) | c) | (c & d)
//   y = c & d
// and the result is presented with the winner's index until the consumer
// accepts it. Completed transactions are counted in a saturating counter.
//
// Transaction flow: IDLE -> LOAD -> EVAL -> RESP -> IDLE
//   IDLE : wait for any request; select a winner at the sampling edge.
//   LOAD : gnt one-hot on the winner for this single cycle; operand latched.
//   EVAL : result registered from the latched operand.
//   RESP : res_valid high, result held until res_ack.
//
// Configuration macro:
//   FIXED_PRIO_EN  defined   -> fixed priority, requester 0 highest.
//                  undefined -> round-robin (default), requester 0 highest
//                               after reset, search resumes after last winner.
//
// Parameters:
//   CNT_W      width of the completed-transaction counter (default 8)
//
// Ports:
//   clk        in   1      clock, all state changes on the rising edge
//   rst        in   1      synchronous active-high reset, highest priority
//   req        in   4      request lines, bit i = requester i
//   op         in   16     operand nibbles, requester i on op[4i+3:4i]
//   res_ack    in   1      consumer accepts the presented result
//   gnt        out  4      one-hot grant, registered, high only in LOAD
//   busy       out  1      registered, high in every state except IDLE
//   res_valid  out  1      registered, high in RESP
//   res_x      out  1      x result
//   res_y      out  1      y result
//   res_id     out  2      index of the requester owning the result
//   cnt        out  CNT_W  completed transactions, saturating
// -----------------------------------------------------------------------------
module arbitro_compuerta #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [15:0]      op,
  input  logic             res_ack,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic             res_valid,
  output logic             res_x,
  output logic             res_y,
  output logic [1:0]       res_id,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       any_req;
  logic [1:0] sel_idx;   // arbitration result, meaningful when any_req
  logic [1:0] winner;    // requester owning the transaction in flight
  logic [3:0] operand;   // latched {a,b,c,d} of the winner
  logic [3:0] op_sel;    // winner's nibble on the op bus
  logic       x_calc;
  logic       y_calc;
  logic       grant_now; // a new transaction starts at this edge

  assign any_req   = |req;
  assign grant_now = (state == IDLE) && any_req;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef FIXED_PRIO_EN

  // Scan from the lowest-priority end so the lowest active index is kept.
  always_comb begin
    sel_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) sel_idx = 2'(i);
    end
  end

`else

  logic [1:0] last_winner;
  logic       found;
  logic [1:0] cand;

  // Candidate order is last_winner+1, +2, +3, then last_winner itself; the
  // 2-bit addition provides the 3 -> 0 wrap.
  // NOTE: every variable written here gets a default first; a path that
  // skipped an assignment would infer a latch.
  always_comb begin
    sel_idx = 2'd0;
    found   = 1'b0;
    cand    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = last_winner + 2'(k + 1);
      if (!found && req[cand]) begin
        sel_idx = cand;
        found   = 1'b1;
      end
    end
  end

  // Pointer reset value 3 makes requester 0 the first candidate. It moves
  // only when a grant is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= 2'd3;
    end else if (grant_now) begin
      last_winner <= sel_idx;
    end
  end

`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (any_req) state_nxt = LOAD;
      LOAD: state_nxt = EVAL;
      EVAL: state_nxt = RESP;
      RESP: if (res_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  assign op_sel = op[{winner, 2'b00} +: 4];

  // operand = {a,b,c,d}
  assign x_calc = ~((operand[3] & operand[2]) | operand[1]) | (operand[1] & operand[0]);
  assign y_calc = operand[1] & operand[0];

  // ---------------------------------------------------------------------------
  // State, registered control outputs and datapath
  // ---------------------------------------------------------------------------
  // Control outputs are decoded from the next state and registered, so they
  // line up with the state they describe and never glitch.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_x     <= 1'b0;
      res_y     <= 1'b0;
      res_id    <= 2'd0;
      winner    <= 2'd0;
      // NOTE: the operand register is cleared on reset as well, so no value
      // from an aborted transaction survives into the next one.
      operand   <= 4'b0000;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= (state_nxt == LOAD) ? (4'b0001 << sel_idx) : 4'b0000;
      busy      <= (state_nxt != IDLE);
      res_valid <= (state_nxt == RESP);

      // Winner frozen at selection; later req changes cannot disturb it.
      if (grant_now) begin
        winner <= sel_idx;
      end

      // op is only looked at while granted.
      if (state == LOAD) begin
        operand <= op_sel;
      end

      // Result is written once per transaction and then held through RESP.
      if (state == EVAL) begin
        res_x  <= x_calc;
        res_y  <= y_calc;
        res_id <= winner;
      end

      // Count on acceptance; stop at all-ones instead of wrapping.
      if ((state == RESP) && res_ack && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_arbitro_compuerta.sv
// -----------------------------------------------------------------------------
// tb_arbitro_compuerta
//
// Directed bench for arbitro_compuerta. Two instances share all inputs: the
// default-width one (CNT_W=8) and a narrow one (CNT_W=2) used to observe
// counter saturation. Inputs change and outputs are sampled 1 time unit after
// each rising edge. Build with +define+FIXED_PRIO_EN to check the fixed
// priority variant.
// -----------------------------------------------------------------------------
module tb_arbitro_compuerta;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] op;
  logic        res_ack;

  logic [3:0]  gnt;
  logic        busy;
  logic        res_valid;
  logic        res_x;
  logic        res_y;
  logic [1:0]  res_id;
  logic [7:0]  cnt;

  logic [3:0]  gnt_s;
  logic        busy_s;
  logic        res_valid_s;
  logic        res_x_s;
  logic        res_y_s;
  logic [1:0]  res_id_s;
  logic [1:0]  cnt_s;

  int checks;
  int errors;
  int exp_cnt;     // expected cnt of the wide instance
  int exp_cnt_s;   // expected cnt of the narrow instance

  arbitro_compuerta #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .res_ack   (res_ack),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_x     (res_x),
    .res_y     (res_y),
    .res_id    (res_id),
    .cnt       (cnt)
  );

  arbitro_compuerta #(.CNT_W(2)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .res_ack   (res_ack),
    .gnt       (gnt_s),
    .busy      (busy_s),
    .res_valid (res_valid_s),
    .res_x     (res_x_s),
    .res_y     (res_y_s),
    .res_id    (res_id_s),
    .cnt       (cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference equations for {x,y} from a nibble {a,b,c,d}.
  function automatic logic [1:0] xy_model(input logic [3:0] n);
    logic a, b, c, d;
    {a, b, c, d} = n;
    return {(~((a & b) | c)) | (c & d), c & d};
  endfunction

  function automatic void count_done();
    exp_cnt   = exp_cnt + 1;
    exp_cnt_s = (exp_cnt_s < 3) ? exp_cnt_s + 1 : 3;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = 4'b0; op = 16'h0; res_ack = 1'b0;
    tick();
    rst = 1'b0;
    exp_cnt = 0; exp_cnt_s = 0;
  endtask

  // One full transaction with res_ack held high. Called in an IDLE cycle;
  // returns in the IDLE cycle that follows acceptance. req is left as given.
  task automatic do_txn(input logic [3:0] r, input logic [15:0] o,
                        output logic [3:0] g, output logic v, output logic x,
                        output logic y, output logic [1:0] id,
                        output logic [7:0] c, output logic [1:0] cs,
                        output logic b_idle);
    req = r; op = o; res_ack = 1'b1;
    tick();                       // LOAD
    g = gnt;
    tick();                       // EVAL
    tick();                       // RESP
    v = res_valid; x = res_x; y = res_y; id = res_id;
    tick();                       // back in IDLE
    c = cnt; cs = cnt_s; b_idle = busy;
    count_done();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; op = 16'hFFFF; res_ack = 1'b1;
    tick();
    tick();
    checks++;
    if ({gnt, busy, res_valid, res_x, res_y, res_id} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b busy=%b vld=%b x=%b y=%b id=%0d expected all 0",
               gnt, busy, res_valid, res_x, res_y, res_id);
    end
    checks++;
    if (cnt !== 8'd0 || cnt_s !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d expected 0/0", cnt, cnt_s);
    end
    rst = 1'b0; req = 4'b0; op = 16'h0; res_ack = 1'b0;
    exp_cnt = 0; exp_cnt_s = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL idle_no_req got busy=%b gnt=%b expected 0/0000", busy, gnt);
    end
  endtask

  // Single request, cycle-exact latency. req drops after LOAD.
  task automatic test_single();
    req = 4'b0100; op = 16'h0C00; res_ack = 1'b1;
    tick();                                   // N+1
    checks++;
    if (gnt !== 4'b0100 || busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_load got gnt=%b busy=%b vld=%b expected 0100/1/0", gnt, busy, res_valid);
    end
    req = 4'b0000;
    tick();                                   // N+2
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_eval got gnt=%b busy=%b vld=%b expected 0000/1/0", gnt, busy, res_valid);
    end
    tick();                                   // N+3
    checks++;
    if (res_valid !== 1'b1 || res_x !== 1'b0 || res_y !== 1'b0 || res_id !== 2'd2) begin
      errors++;
      $display("FAIL single_resp got vld=%b x=%b y=%b id=%0d expected 1/0/0/2",
               res_valid, res_x, res_y, res_id);
    end
    tick();                                   // IDLE
    count_done();
    checks++;
    if (cnt !== 8'd1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done got cnt=%0d busy=%b vld=%b expected 1/0/0", cnt, busy, res_valid);
    end
  endtask

  // Requester 0 alone, all 16 operand values.
  task automatic test_function();
    logic [3:0] g; logic v, x, y, bi; logic [1:0] id, cs; logic [7:0] c;
    logic [1:0] e;
    for (int n = 0; n < 16; n++) begin
      do_txn(4'b0001, {12'hABC, 4'(n)}, g, v, x, y, id, c, cs, bi);
      e = xy_model(4'(n));
      checks++;
      if (g !== 4'b0001 || v !== 1'b1 || id !== 2'd0) begin
        errors++;
        $display("FAIL func_ctl op=%h got gnt=%b vld=%b id=%0d expected 0001/1/0", n, g, v, id);
      end
      checks++;
      if ({x, y} !== e) begin
        errors++;
        $display("FAIL func_xy op=%h got x=%b y=%b expected x=%b y=%b", n, x, y, e[1], e[0]);
      end
    end
    req = 4'b0000;
    checks++;
    if (c !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL func_cnt got %0d expected %0d", c, exp_cnt);
    end
  endtask

  // res_ack high with no transaction in flight changes nothing.
  task automatic test_ack_outside();
    req = 4'b0000; res_ack = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || gnt !== 4'b0 || cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL ack_idle got busy=%b vld=%b gnt=%b cnt=%0d expected 0/0/0000/%0d",
               busy, res_valid, gnt, cnt, exp_cnt);
    end
    res_ack = 1'b0;
  endtask

  // All four requesting continuously; grants every 4 cycles.
  task automatic test_fairness();
    logic [3:0] g; logic v, x, y, bi; logic [1:0] id, cs; logic [7:0] c;
    logic [3:0] exp_g [5];
`ifdef FIXED_PRIO_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_txn(4'b1111, 16'h0000, g, v, x, y, id, c, cs, bi);
      checks++;
      if (g !== exp_g[k]) begin
        errors++;
        $display("FAIL fair_gnt[%0d] got %b expected %b", k, g, exp_g[k]);
      end
    end
    req = 4'b0000;
    checks++;
    if (c !== 8'd5) begin
      errors++;
      $display("FAIL fair_cnt got %0d expected 5", c);
    end
  endtask

  // Held RESP with op/req disturbed after LOAD.
  task automatic test_backpressure();
    req = 4'b0010; op = 16'h0030; res_ack = 1'b0;   // nibble 1 = 0011 -> x=1,y=1
    tick();                                          // LOAD
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL bp_gnt got %b expected 0010", gnt);
    end
    tick();                                          // EVAL
    op = 16'h00C0; req = 4'b1111;                    // would give x=0,y=0
    tick();                                          // RESP
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (res_valid !== 1'b1 || res_x !== 1'b1 || res_y !== 1'b1 || res_id !== 2'd1
          || gnt !== 4'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d] got vld=%b x=%b y=%b id=%0d gnt=%b busy=%b expected 1/1/1/1/0000/1",
                 k, res_valid, res_x, res_y, res_id, gnt, busy);
      end
      op = 16'(k * 16'h1111); req = 4'(k);
      tick();
    end
    req = 4'b0000; res_ack = 1'b1;
    tick();                                          // back to IDLE
    res_ack = 1'b0;
    count_done();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL bp_release got vld=%b busy=%b cnt=%0d expected 0/0/%0d",
               res_valid, busy, cnt, exp_cnt);
    end
  endtask

  // Reset asserted while in EVAL; the transaction must vanish.
  task automatic test_reset_mid();
    logic [3:0] g; logic v, x, y, bi; logic [1:0] id, cs; logic [7:0] c;
    do_reset();
    req = 4'b0001; op = 16'h0003; res_ack = 1'b1;
    tick();                                          // LOAD
    req = 4'b0000;
    tick();                                          // EVAL
    rst = 1'b1;
    tick();
    checks++;
    if ({gnt, busy, res_valid, res_x, res_y, res_id} !== 10'b0 || cnt !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_out got gnt=%b busy=%b vld=%b x=%b y=%b id=%0d cnt=%0d expected zeros",
               gnt, busy, res_valid, res_x, res_y, res_id, cnt);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (res_valid !== 1'b0 || cnt !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_discard got vld=%b cnt=%0d busy=%b expected 0/0/0", res_valid, cnt, busy);
    end
    do_txn(4'b1111, 16'h0000, g, v, x, y, id, c, cs, bi);
    req = 4'b0000;
    checks++;
    if (g !== 4'b0001 || id !== 2'd0 || c !== 8'd1) begin
      errors++;
      $display("FAIL rstmid_next got gnt=%b id=%0d cnt=%0d expected 0001/0/1", g, id, c);
    end
  endtask

  // Narrow counter saturates at 3; wide counter keeps counting.
  task automatic test_saturation();
    logic [3:0] g; logic v, x, y, bi; logic [1:0] id, cs; logic [7:0] c;
    logic [1:0] exp_s [5];
    exp_s = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_txn(4'b1000, 16'h5000, g, v, x, y, id, c, cs, bi);
      checks++;
      if (cs !== exp_s[k] || c !== 8'(k + 1) || bi !== 1'b0) begin
        errors++;
        $display("FAIL sat[%0d] got cnt_s=%0d cnt=%0d busy=%b expected %0d/%0d/0",
                 k, cs, c, bi, exp_s[k], k + 1);
      end
    end
    req = 4'b0000;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    checks = 0; errors = 0; exp_cnt = 0; exp_cnt_s = 0;
    rst = 1'b1; req = 4'b0; op = 16'h0; res_ack = 1'b0;
    test_reset();
    test_single();
    test_function();
    test_ack_outside();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got no completion expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
